mod_counter_ctrl: RTL and testbench



---
 rtl/mod_counter_ctrl.sv | 143 ++++++++++++++
 tb/tb_mod_counter_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter_ctrl.sv
// Sequencing controller around a modulo-N counter with loop count,
// hold and abort. Optional down counting: define DOWN_COUNT_EN.
module mod_counter_ctrl #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 5,
  parameter int LW      = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [LW-1:0]    LOOPS,
  input  logic             DIR,
  input  logic             HOLD,
  input  logic             ABORT,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAXQ = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MODULUS);

  state_t          state, state_n;
  logic [WIDTH-1:0] q_n;
  logic            co_n, busy_n, done_n;
  logic [LW-1:0]   rem, rem_n;
  logic            wrap;
  logic            down;

`ifdef DOWN_COUNT_EN
  logic dir_q, dir_n;
  assign down = dir_q;
`else
  logic unused_dir;
  assign unused_dir = DIR;
  assign down = 1'b0;
`endif

  // next-state, next-count and output decode
  always_comb begin
    state_n = state;
    q_n     = Q;
    co_n    = 1'b0;
    done_n  = 1'b0;
    rem_n   = rem;
    wrap    = 1'b0;
`ifdef DOWN_COUNT_EN
    dir_n   = dir_q;
`endif
    if (ABORT) begin
      state_n = IDLE;
      q_n     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          q_n = '0;
          if (START) begin
            state_n = RUN;
            rem_n   = LOOPS;
`ifdef DOWN_COUNT_EN
            dir_n   = DIR;
`endif
          end
        end
        RUN: begin
          if (!HOLD) begin
            if ({1'b0, Q} >= MODW) begin
              q_n = '0;
            end else if (down) begin
              if (Q == '0) begin
                q_n  = MAXQ;
                wrap = 1'b1;
              end else begin
                q_n = Q - 1'b1;
              end
            end else begin
              if (Q == MAXQ) begin
                q_n  = '0;
                wrap = 1'b1;
              end else begin
                q_n = Q + 1'b1;
              end
            end
            if (wrap) begin
              co_n = 1'b1;
              if (rem != '0) begin
                rem_n = rem - 1'b1;
                if (rem == LW'(1)) begin
                  state_n = FIN;
                  done_n  = 1'b1;
                end
              end
            end
          end
        end
        FIN: begin
          state_n = IDLE;
          q_n     = '0;
        end
        default: begin
          state_n = IDLE;
          q_n     = '0;
        end
      endcase
    end
    busy_n = (state_n == RUN);
  end

  // state, count and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      Q     <= '0;
      CO    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      rem   <= '0;
    end else begin
      state <= state_n;
      Q     <= q_n;
      CO    <= co_n;
      BUSY  <= busy_n;
      DONE  <= done_n;
      rem   <= rem_n;
    end
  end

`ifdef DOWN_COUNT_EN
  // latched count direction
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) dir_q <= 1'b0;
    else        dir_q <= dir_n;
  end
`endif

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed scoreboard bench for mod_counter_ctrl (mod-5, 3-bit).
// Expected outputs are queued per edge and popped after it.
module tb_mod_counter_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic [3:0] LOOPS;
  logic       DIR;
  logic       HOLD;
  logic       ABORT;
  logic [2:0] Q;
  logic       CO;
  logic       BUSY;
  logic       DONE;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0] q;
    logic       co;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb[$];

  mod_counter_ctrl #(
    .WIDTH(3),
    .MODULUS(5),
    .LW(4)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .START(START),
    .LOOPS(LOOPS),
    .DIR(DIR),
    .HOLD(HOLD),
    .ABORT(ABORT),
    .Q(Q),
    .CO(CO),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int q,
                      input int co, input int busy, input int done);
    exp_t e;
    e.q    = 3'(q);
    e.co   = co[0];
    e.busy = busy[0];
    e.done = done[0];
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".Q"},    int'(Q),    int'(e.q));
      chk({e.tag, ".CO"},   int'(CO),   int'(e.co));
      chk({e.tag, ".BUSY"}, int'(BUSY), int'(e.busy));
      chk({e.tag, ".DONE"}, int'(DONE), int'(e.done));
    end
  endtask

  task automatic cyc(input string tag, input int q,
                     input int co, input int busy, input int done);
    push(tag, q, co, busy, done);
    @(posedge CLK);
    #1;
    pop_cmp();
  endtask

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    LOOPS = 4'd0;
    DIR   = 1'b0;
    HOLD  = 1'b0;
    ABORT = 1'b0;
    #2;
    push("reset", 0, 0, 0, 0);
    pop_cmp();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc("idle", 0, 0, 0, 0);

    // LOOPS=2 up: wraps at j=5 and j=10, DONE with final CO
    START = 1'b1;
    LOOPS = 4'd2;
    cyc("l2_start", 0, 0, 1, 0);
    START = 1'b0;
    LOOPS = 4'd0;
    for (int j = 1; j <= 10; j++)
      cyc($sformatf("l2_j%0d", j), j % 5, (j % 5 == 0) ? 1 : 0,
          (j == 10) ? 0 : 1, (j == 10) ? 1 : 0);
    cyc("l2_idle", 0, 0, 0, 0);

    // LOOPS=1 with 3 held cycles at Q=2
    START = 1'b1;
    LOOPS = 4'd1;
    cyc("h_start", 0, 0, 1, 0);
    START = 1'b0;
    cyc("h_q1", 1, 0, 1, 0);
    cyc("h_q2", 2, 0, 1, 0);
    HOLD = 1'b1;
    for (int j = 0; j < 3; j++)
      cyc($sformatf("h_hold%0d", j), 2, 0, 1, 0);
    HOLD = 1'b0;
    cyc("h_q3", 3, 0, 1, 0);
    cyc("h_q4", 4, 0, 1, 0);
    cyc("h_fin", 0, 1, 0, 1);
    cyc("h_idle", 0, 0, 0, 0);

    // LOOPS=0 free run, stray START, ABORT at Q=4
    START = 1'b1;
    LOOPS = 4'd0;
    cyc("a_start", 0, 0, 1, 0);
    START = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      START = (j == 2) ? 1'b1 : 1'b0;
      LOOPS = (j == 2) ? 4'd1 : 4'd0;
      cyc($sformatf("a_j%0d", j), j % 5, (j % 5 == 0) ? 1 : 0, 1, 0);
    end
    START = 1'b0;
    LOOPS = 4'd0;
    ABORT = 1'b1;
    cyc("a_abort", 0, 0, 0, 0);
    ABORT = 1'b0;
    cyc("a_after0", 0, 0, 0, 0);
    cyc("a_after1", 0, 0, 0, 0);

    // START and ABORT together in IDLE
    START = 1'b1;
    ABORT = 1'b1;
    LOOPS = 4'd1;
    cyc("sa_both", 0, 0, 0, 0);
    START = 1'b0;
    ABORT = 1'b0;
    cyc("sa_idle", 0, 0, 0, 0);

`ifdef DOWN_COUNT_EN
    // down count, LOOPS=1: first step from 0 borrows and finishes
    START = 1'b1;
    LOOPS = 4'd1;
    DIR   = 1'b1;
    cyc("d_start", 0, 0, 1, 0);
    START = 1'b0;
    DIR   = 1'b0;
    cyc("d_fin", 4, 1, 0, 1);
    cyc("d_idle", 0, 0, 0, 0);

    // down count, LOOPS=2: 4 after borrow, then 3,2,1,0, borrow
    START = 1'b1;
    LOOPS = 4'd2;
    DIR   = 1'b1;
    cyc("d2_start", 0, 0, 1, 0);
    START = 1'b0;
    DIR   = 1'b0;
    cyc("d2_w1", 4, 1, 1, 0);
    cyc("d2_q3", 3, 0, 1, 0);
    cyc("d2_q2", 2, 0, 1, 0);
    cyc("d2_q1", 1, 0, 1, 0);
    cyc("d2_q0", 0, 0, 1, 0);
    cyc("d2_fin", 4, 1, 0, 1);
    cyc("d2_idle", 0, 0, 0, 0);
`endif

    // asynchronous reset mid-run at Q=3
    START = 1'b1;
    LOOPS = 4'd0;
    cyc("r_start", 0, 0, 1, 0);
    START = 1'b0;
    cyc("r_q1", 1, 0, 1, 0);
    cyc("r_q2", 2, 0, 1, 0);
    cyc("r_q3", 3, 0, 1, 0);
    #2;
    RST_N = 1'b0;
    #1;
    push("r_async", 0, 0, 0, 0);
    pop_cmp();
    @(posedge CLK);
    #1;
    push("r_held", 0, 0, 0, 0);
    pop_cmp();
    RST_N = 1'b1;
    cyc("r_idle0", 0, 0, 0, 0);
    cyc("r_idle1", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
